// File: rtl/adsr_pkg.sv
// adsr_pkg
//   Shared types and helpers for the polyphonic ADSR envelope.
//   adsr_state_t : per-voice envelope phase (also exported for debug/checkers).
//   sat_add      : a + b clamped to an upper limit.
//   sat_sub      : a - b clamped to a lower floor.
//   Helpers work on SAT_W-bit operands so any WIDTH up to 32 can zero-extend
//   into them without overflow.
package adsr_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } adsr_state_t;

   localparam int SAT_W = 33;
   typedef logic [SAT_W-1:0] sat_t;

   // Returns min(a + b, lim); the extra carry bit keeps the sum exact.
   function automatic sat_t sat_add(input sat_t a, input sat_t b, input sat_t lim);
      logic [SAT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, lim}) return lim;
      return sum[SAT_W-1:0];
   endfunction

   // Returns a - b, or floor when a <= floor + b (never wraps below floor).
   function automatic sat_t sat_sub(input sat_t a, input sat_t b, input sat_t floor);
      logic [SAT_W:0] fb;
      fb = {1'b0, floor} + {1'b0, b};
      if ({1'b0, a} <= fb) return floor;
      return a - b;
   endfunction

endpackage

// File: rtl/adsr_poly_voice.sv
// adsr_voice
//   One envelope channel: state, level and key_prev registers plus the
//   next-state logic. Everything advances only on sample_en.
//   Ports:
//     CLK, RESET   clock, synchronous active-high reset
//     sample_en    one-cycle tick per audio sample
//     key          gate for this voice
//     A, D, S, R   shared attack/decay increments, sustain level, release decrement
//     level        registered envelope level
//     state        current phase (debug / activity)
module adsr_voice
   import adsr_pkg::*;
#(
   parameter int               WIDTH          = 16,
   parameter logic [WIDTH-1:0] PEAK           = WIDTH'((2 ** (WIDTH - 1)) - 1),
   parameter int               RETRIGGER_MODE = 0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             sample_en,
   input  logic             key,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] level,
   output adsr_state_t      state
);

   localparam sat_t PEAK_X = sat_t'(PEAK);

   adsr_state_t      state_d;
   logic [WIDTH-1:0] level_d;
   logic             key_prev;
   logic             key_prev_d;
   logic [WIDTH-1:0] s_eff;
   logic             rise;
   sat_t             atk_base;
   sat_t             atk_res;
   logic             atk_done;
   sat_t             dec_res;
   sat_t             rel_res;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         level    <= '0;
         key_prev <= 1'b0;
      end else begin
         state    <= state_d;
         level    <= level_d;
         key_prev <= key_prev_d;
      end
   end

   always_comb begin
      s_eff = (S > PEAK) ? PEAK : S;
      rise  = key & ~key_prev;

      // A note from IDLE, or a mode-1 retrigger, climbs from zero; otherwise
      // the attack continues from wherever the level currently sits.
      if ((state == IDLE) || ((state == RELEASE) && (RETRIGGER_MODE == 1)))
         atk_base = '0;
      else
         atk_base = sat_t'(level);

      atk_res  = sat_add(atk_base, sat_t'(A), PEAK_X);
      atk_done = (A == '0) || (atk_res == PEAK_X);
      dec_res  = sat_sub(sat_t'(level), sat_t'(D), sat_t'(s_eff));
      rel_res  = sat_sub(sat_t'(level), sat_t'(R), '0);

      state_d    = state;
      level_d    = level;
      key_prev_d = key_prev;

      if (sample_en) begin
         key_prev_d = key;
         case (state)
            IDLE: begin
               if (rise) begin
                  state_d = atk_done ? DECAY : ATTACK;
                  level_d = atk_done ? PEAK : WIDTH'(atk_res);
               end
            end
            ATTACK: begin
               if (!key) begin
                  state_d = RELEASE;
               end else begin
                  state_d = atk_done ? DECAY : ATTACK;
                  level_d = atk_done ? PEAK : WIDTH'(atk_res);
               end
            end
            DECAY: begin
               if (!key) begin
                  state_d = RELEASE;
               end else if ((D == '0) || (dec_res == sat_t'(s_eff))) begin
                  state_d = SUSTAIN;
                  level_d = s_eff;
               end else begin
                  level_d = WIDTH'(dec_res);
               end
            end
            SUSTAIN: begin
               if (!key) state_d = RELEASE;
               else      level_d = s_eff;
            end
            RELEASE: begin
               if (rise) begin
                  state_d = atk_done ? DECAY : ATTACK;
                  level_d = atk_done ? PEAK : WIDTH'(atk_res);
               end else if ((R == '0) || (rel_res == '0)) begin
                  state_d = IDLE;
                  level_d = '0;
               end else begin
                  level_d = WIDTH'(rel_res);
               end
            end
            default: begin
               state_d = IDLE;
               level_d = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/adsr_poly.sv
// adsr_poly
//   NUM_VOICES independent ADSR envelopes sharing A/D/S/R settings.
//   Ports:
//     CLK, RESET   clock, synchronous active-high reset
//     sample_en    one-cycle tick per audio sample
//     key_in       per-voice gate, bit v = voice v
//     A, D, S, R   attack inc, decay dec, sustain level, release dec
//     out          packed levels, voice v at [v*WIDTH +: WIDTH]
//     active       1 while the voice is not IDLE
module adsr_poly
   import adsr_pkg::*;
#(
   parameter int               NUM_VOICES     = 8,
   parameter int               WIDTH          = 16,
   parameter logic [WIDTH-1:0] PEAK           = WIDTH'((2 ** (WIDTH - 1)) - 1),
   parameter int               RETRIGGER_MODE = 0
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        sample_en,
   input  logic [NUM_VOICES-1:0]       key_in,
   input  logic [WIDTH-1:0]            A,
   input  logic [WIDTH-1:0]            D,
   input  logic [WIDTH-1:0]            S,
   input  logic [WIDTH-1:0]            R,
   output logic [NUM_VOICES*WIDTH-1:0] out,
   output logic [NUM_VOICES-1:0]       active
);

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      adsr_state_t st;

      adsr_voice #(
         .WIDTH          (WIDTH),
         .PEAK           (PEAK),
         .RETRIGGER_MODE (RETRIGGER_MODE)
      ) u_voice (
         .CLK       (CLK),
         .RESET     (RESET),
         .sample_en (sample_en),
         .key       (key_in[v]),
         .A         (A),
         .D         (D),
         .S         (S),
         .R         (R),
         .level     (out[v*WIDTH +: WIDTH]),
         .state     (st)
      );

      assign active[v] = (st != IDLE);
   end

endmodule

// File: tb/tb_adsr_poly.sv
// tb_adsr_poly
//   Drives two adsr_poly instances (retrigger modes 0 and 1) from shared
//   inputs and compares them every cycle against an integer envelope model.
module tb_adsr_poly;

  localparam int NV   = 8;
  localparam int W    = 16;
  localparam int PEAK = 32'h7FFF;
  localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic            CLK;
  logic            RESET;
  logic            sample_en;
  logic [NV-1:0]   key_in;
  logic [W-1:0]    A, D, S, R;
  logic [NV*W-1:0] out0, out1;
  logic [NV-1:0]   act0, act1;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [W-1:0] exp_q[$];

  // model state: [mode][voice]
  int m_ph[2][NV];
  int m_lvl[2][NV];
  int m_kp[2][NV];

  adsr_poly #(.NUM_VOICES(NV), .WIDTH(W), .RETRIGGER_MODE(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .sample_en(sample_en), .key_in(key_in),
    .A(A), .D(D), .S(S), .R(R), .out(out0), .active(act0));

  adsr_poly #(.NUM_VOICES(NV), .WIDTH(W), .RETRIGGER_MODE(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .sample_en(sample_en), .key_in(key_in),
    .A(A), .D(D), .S(S), .R(R), .out(out1), .active(act1));

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- reference model ----------------
  function automatic int attack_level(input int base, input int a);
    if (a == 0 || base + a >= PEAK) return PEAK;
    return base + a;
  endfunction

  always @(posedge CLK) begin
    int k, rise, seff, a, d, s, r, lv;
    a = int'(A); d = int'(D); s = int'(S); r = int'(R);
    seff = (s > PEAK) ? PEAK : s;
    for (int md = 0; md < 2; md++) begin
      for (int v = 0; v < NV; v++) begin
        if (RESET) begin
          m_ph[md][v] = P_IDLE; m_lvl[md][v] = 0; m_kp[md][v] = 0;
        end else if (sample_en) begin
          k = int'(key_in[v]);
          rise = (k == 1 && m_kp[md][v] == 0) ? 1 : 0;
          m_kp[md][v] = k;
          lv = m_lvl[md][v];
          case (m_ph[md][v])
            P_IDLE: if (rise == 1) begin
              lv = attack_level(0, a);
              m_ph[md][v] = (lv == PEAK) ? P_DEC : P_ATK;
            end
            P_ATK: if (k == 0) m_ph[md][v] = P_REL;
              else begin
                lv = attack_level(lv, a);
                m_ph[md][v] = (lv == PEAK) ? P_DEC : P_ATK;
              end
            P_DEC: if (k == 0) m_ph[md][v] = P_REL;
              else if (d == 0 || lv <= seff + d) begin lv = seff; m_ph[md][v] = P_SUS; end
              else lv = lv - d;
            P_SUS: if (k == 0) m_ph[md][v] = P_REL; else lv = seff;
            default: if (rise == 1) begin
                lv = (md == 0) ? attack_level(lv, a) : ((a == 0) ? PEAK : ((a < PEAK) ? a : PEAK));
                m_ph[md][v] = (lv == PEAK) ? P_DEC : P_ATK;
              end else if (r == 0 || lv <= r) begin lv = 0; m_ph[md][v] = P_IDLE; end
              else lv = lv - r;
          endcase
          m_lvl[md][v] = lv;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act_v, exp_v);
    end
  endtask

  always @(negedge CLK) begin
    logic [NV*W-1:0] e_out;
    logic [NV-1:0]   e_act;
    if (chk_en) begin
      for (int md = 0; md < 2; md++) begin
        for (int v = 0; v < NV; v++) begin
          e_out[v*W +: W] = W'(m_lvl[md][v]);
          e_act[v]        = (m_ph[md][v] != P_IDLE);
        end
        checks++;
        if (((md == 0) ? out0 : out1) !== e_out) begin
          errors++;
          $display("FAIL model_out mode%0d actual=%h required=%h", md, (md == 0) ? out0 : out1, e_out);
        end
        checks++;
        if (((md == 0) ? act0 : act1) !== e_act) begin
          errors++;
          $display("FAIL model_active mode%0d actual=%b required=%b", md, (md == 0) ? act0 : act1, e_act);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_tick();
    sample_en = 1'b1;
    @(negedge CLK);
    sample_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic set_rates(input int a, input int d, input int s, input int r);
    A = W'(a); D = W'(d); S = W'(s); R = W'(r);
  endtask

  function automatic logic [W-1:0] lvl0(input int v);
    return out0[v*W +: W];
  endfunction

  function automatic logic [W-1:0] lvl1(input int v);
    return out1[v*W +: W];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] e;
    RESET = 1'b1; sample_en = 1'b0; key_in = '0;
    set_rates(0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    chk("reset_out0", 32'(out0[31:0]), 32'h0);
    chk("reset_act0", 32'(act0), 32'h0);
    chk("reset_act1", 32'(act1), 32'h0);
    RESET = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    // full envelope on voice 0
    set_rates(32'h1000, 32'h0800, 32'h4000, 32'h2000);
    key_in[0] = 1'b1;
    for (int i = 1; i <= 7; i++) exp_q.push_back(W'(i * 32'h1000));
    exp_q.push_back(16'h7FFF);
    for (int i = 1; i <= 7; i++) exp_q.push_back(W'(32'h7FFF - i * 32'h0800));
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h4000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      do_tick();
      chk("full_cycle", 32'(lvl0(0)), 32'(e));
    end
    // gating: 50 idle cycles with the key held leave the level frozen
    repeat (50) @(negedge CLK);
    chk("gated_hold", 32'(lvl0(0)), 32'h4000);
    key_in[0] = 1'b0;
    do_tick(); chk("rel_enter", 32'(lvl0(0)), 32'h4000);
    do_tick(); chk("rel_step1", 32'(lvl0(0)), 32'h2000);
    do_tick(); chk("rel_zero", 32'(lvl0(0)), 32'h0);
    chk("rel_inactive", 32'(act0[0]), 32'h0);

    // retrigger while releasing at 0x3000 (voice 1)
    set_rates(32'h1000, 32'h0800, 32'h4000, 32'h1000);
    key_in[1] = 1'b1;
    ticks(18);
    chk("retrig_sus", 32'(lvl0(1)), 32'h4000);
    key_in[1] = 1'b0;
    ticks(2);
    chk("retrig_rel0", 32'(lvl0(1)), 32'h3000);
    chk("retrig_rel1", 32'(lvl1(1)), 32'h3000);
    key_in[1] = 1'b1;
    do_tick();
    chk("retrig_mode0", 32'(lvl0(1)), 32'h4000);
    chk("retrig_mode1", 32'(lvl1(1)), 32'h1000);
    key_in[1] = 1'b0;
    ticks(10);

    // zero rates and sustain clamp (voice 2)
    set_rates(0, 0, 32'h9000, 0);
    key_in[2] = 1'b1;
    do_tick(); chk("zero_peak", 32'(lvl0(2)), 32'h7FFF);
    do_tick(); chk("zero_sus_clamp", 32'(lvl0(2)), 32'h7FFF);
    key_in[2] = 1'b0;
    do_tick(); chk("zero_rel_enter", 32'(lvl0(2)), 32'h7FFF);
    do_tick(); chk("zero_rel_done", 32'(lvl0(2)), 32'h0);
    chk("zero_inactive", 32'(act0[2]), 32'h0);

    // early release from attack (voice 3)
    set_rates(32'h1000, 32'h0800, 32'h4000, 32'h1000);
    key_in[3] = 1'b1;
    ticks(3);
    chk("early_atk", 32'(lvl0(3)), 32'h3000);
    key_in[3] = 1'b0;
    do_tick(); chk("early_rel_enter", 32'(lvl0(3)), 32'h3000);
    do_tick(); chk("early_rel_step", 32'(lvl0(3)), 32'h2000);
    ticks(5);

    // reset mid-attack with key held through it
    key_in[0] = 1'b1;
    ticks(2);
    chk("pre_reset_atk", 32'(lvl0(0)), 32'h2000);
    RESET = 1'b1; sample_en = 1'b1;
    @(negedge CLK);
    chk("midreset_out0", 32'(out0[31:0]), 32'h0);
    chk("midreset_out1", 32'(out1[31:0]), 32'h0);
    chk("midreset_act", 32'({act1, act0}), 32'h0);
    RESET = 1'b0; sample_en = 1'b0;
    do_tick();
    chk("post_reset_attack", 32'(lvl0(0)), 32'h1000);
    key_in[0] = 1'b0;
    ticks(10);

    // randomized phase, checked against the model every cycle
    for (int i = 0; i < 6000; i++) begin
      sample_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) key_in[$urandom_range(0, NV-1)] ^= 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0: A = W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 32'h3000));
          1: D = W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 32'h3000));
          2: S = W'($urandom_range(0, 32'hFFFF));
          default: R = W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 32'h3000));
        endcase
        if ($urandom_range(0, 7) == 0) A = 16'hFFFF;
      end
      RESET = ($urandom_range(0, 1999) == 0);
      @(negedge CLK);
    end
    RESET = 1'b0;
    sample_en = 1'b0;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
